// File: rtl/envelope_shaper_if.sv
// envelope_shaper_if: note controls, sample stream and envelope status for one envelope_shaper
interface envelope_shaper_if #(
  parameter int N = 8,
  parameter int E = 8
);
  logic         sample_en;
  logic         note_on;
  logic         note_off;
  logic [N-1:0] sample_in;
  logic [N-1:0] sample_out;
  logic [E-1:0] env_level;
  logic [2:0]   env_state;
  logic         busy;
  modport master (
    output sample_en, note_on, note_off, sample_in,
    input  sample_out, env_level, env_state, busy
  );
  modport slave (
    input  sample_en, note_on, note_off, sample_in,
    output sample_out, env_level, env_state, busy
  );
endinterface

// File: rtl/envelope_shaper.sv
// envelope_shaper: ADSR envelope scaling sine magnitude samples; define ENVELOPE_EXP_RELEASE_EN for an exponential-like release
module envelope_shaper #(
  parameter int N             = 8,
  parameter int E             = 8,
  parameter int ATTACK_STEP   = 64,
  parameter int DECAY_STEP    = 16,
  parameter int SUSTAIN_LEVEL = 128,
  parameter int RELEASE_STEP  = 32
) (
  input  logic clk,
  input  logic reset,
  envelope_shaper_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
  localparam logic [E:0] ENV_MAX = {1'b0, {E{1'b1}}};
  localparam logic [E:0] A_STEP  = (E+1)'(ATTACK_STEP);
  localparam logic [E:0] D_STEP  = (E+1)'(DECAY_STEP);
  localparam logic [E:0] SUS     = (E+1)'(SUSTAIN_LEVEL);
`ifndef ENVELOPE_EXP_RELEASE_EN
  localparam logic [E:0] R_STEP  = (E+1)'(RELEASE_STEP);
`endif
  state_t         state_q, state_d;
  logic [E-1:0]   level_q, level_d;
  logic [N-1:0]   sample_q, sample_d;
  logic [E:0]     lvl_x, sum, diff_d, diff_r;
  logic [N+E-1:0] prod;
  logic           ev_off;
  // envelope state, level and scaled output sample
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      sample_q <= sample_d;
    end
  // note events take priority over the per-tick level step; scaling uses the pre-step level
  always_comb begin
    lvl_x  = {1'b0, level_q};
    sum    = lvl_x + A_STEP;
    diff_d = lvl_x - D_STEP;
`ifdef ENVELOPE_EXP_RELEASE_EN
    diff_r = lvl_x - (lvl_x >> 3) - (E+1)'(1);
`else
    diff_r = lvl_x - R_STEP;
`endif
    prod     = (N+E)'(bus.sample_in) * (N+E)'(level_q);
    ev_off   = bus.note_off && (state_q inside {ATTACK, DECAY, SUSTAIN});
    state_d  = state_q;
    level_d  = level_q;
    sample_d = bus.sample_en ? (lvl_x == ENV_MAX ? bus.sample_in : N'(prod >> E)) : sample_q;
    if (bus.note_on) state_d = ATTACK;
    else if (ev_off) state_d = RELEASE;
    else if (bus.sample_en)
      case (state_q)
        ATTACK: begin
          level_d = sum >= ENV_MAX ? ENV_MAX[E-1:0] : sum[E-1:0];
          state_d = sum >= ENV_MAX ? DECAY : ATTACK;
        end
        DECAY: begin
          level_d = (diff_d[E] || diff_d <= SUS) ? SUS[E-1:0] : diff_d[E-1:0];
          state_d = (diff_d[E] || diff_d <= SUS) ? SUSTAIN : DECAY;
        end
        RELEASE: begin
          level_d = (diff_r[E] || diff_r == '0) ? '0 : diff_r[E-1:0];
          state_d = (diff_r[E] || diff_r == '0) ? IDLE : RELEASE;
        end
        default: ;
      endcase
  end
  assign bus.sample_out = sample_q;
  assign bus.env_level  = level_q;
  assign bus.env_state  = state_q;
  assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_envelope_shaper.sv
// tb_envelope_shaper: directed checks of the ADSR envelope and sample scaling
module tb_envelope_shaper;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  envelope_shaper_if #(.N(8), .E(8)) bus ();
  envelope_shaper dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic int exp_rel(input int l);
    int r;
    r = l - (l >> 3) - 1;
    return r < 0 ? 0 : r;
  endfunction

  task automatic tick();
    @(negedge clk) bus.sample_en = 1'b1;
    @(negedge clk) bus.sample_en = 1'b0;
  endtask

  task automatic pulse_on();
    @(negedge clk) bus.note_on = 1'b1;
    @(negedge clk) bus.note_on = 1'b0;
  endtask

  task automatic pulse_off();
    @(negedge clk) bus.note_off = 1'b1;
    @(negedge clk) bus.note_off = 1'b0;
  endtask

  task automatic test_reset();
    bus.sample_en = 0; bus.note_on = 0; bus.note_off = 0; bus.sample_in = 8'd200;
    #1;
    total++;
    if ({bus.env_state, bus.env_level, bus.sample_out, bus.busy} !== 20'd0) begin
      bad++; $display("FAIL reset_hold got st=%0d lv=%0d out=%0d busy=%0b want all 0", bus.env_state, bus.env_level, bus.sample_out, bus.busy);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({bus.env_state, bus.env_level, bus.sample_out, bus.busy} !== 20'd0) begin
        bad++; $display("FAIL idle_tick%0d got st=%0d lv=%0d out=%0d busy=%0b want all 0", i, bus.env_state, bus.env_level, bus.sample_out, bus.busy);
      end
    end
  endtask

  task automatic test_attack_decay();
    int lv[12] = '{64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128};
    int st[12] = '{1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    int so[12] = '{0, 25, 50, 75, 100, 93, 87, 80, 74, 68, 62, 55};
    bus.sample_in = 8'd100;
    pulse_on();
    total++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'd0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL note_on got st=%0d lv=%0d busy=%0b want st=1 lv=0 busy=1", bus.env_state, bus.env_level, bus.busy);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (bus.env_level !== 8'(lv[i]) || bus.env_state !== 3'(st[i]) || bus.sample_out !== 8'(so[i])) begin
        bad++; $display("FAIL adsr_tick%0d got lv=%0d st=%0d out=%0d want lv=%0d st=%0d out=%0d", i + 1, bus.env_level, bus.env_state, bus.sample_out, lv[i], st[i], so[i]);
      end
    end
  endtask

  task automatic test_scaling();
    bus.sample_in = 8'd200;
    tick();
    total++;
    if (bus.sample_out !== 8'd100 || bus.env_level !== 8'd128) begin
      bad++; $display("FAIL scale_200 got out=%0d lv=%0d want out=100 lv=128", bus.sample_out, bus.env_level);
    end
    bus.sample_in = 8'd255;
    tick();
    total++;
    if (bus.sample_out !== 8'd127) begin
      bad++; $display("FAIL scale_255 got %0d want 127", bus.sample_out);
    end
    bus.sample_in = 8'd10;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.sample_out !== 8'd127) begin
      bad++; $display("FAIL scale_hold got %0d want 127", bus.sample_out);
    end
  endtask

  task automatic test_release();
    int m;
    pulse_off();
    total++;
    if (bus.env_state !== 3'd4 || bus.env_level !== 8'd128) begin
      bad++; $display("FAIL note_off got st=%0d lv=%0d want st=4 lv=128", bus.env_state, bus.env_level);
    end
`ifdef ENVELOPE_EXP_RELEASE_EN
    m = 128;
    for (int i = 0; i < 60 && m > 0; i++) begin
      m = exp_rel(m);
      tick();
      total++;
      if (bus.env_level !== 8'(m) || bus.env_state !== (m == 0 ? 3'd0 : 3'd4)) begin
        bad++; $display("FAIL exp_rel_tick%0d got lv=%0d st=%0d want lv=%0d", i + 1, bus.env_level, bus.env_state, m);
      end
    end
`else
    m = 128;
    for (int i = 0; i < 4; i++) begin
      m = m - 32;
      tick();
      total++;
      if (bus.env_level !== 8'(m) || bus.env_state !== (i == 3 ? 3'd0 : 3'd4)) begin
        bad++; $display("FAIL rel_tick%0d got lv=%0d st=%0d want lv=%0d", i + 1, bus.env_level, bus.env_state, m);
      end
    end
`endif
    total++;
    if (bus.busy !== 1'b0 || bus.env_state !== 3'd0) begin
      bad++; $display("FAIL rel_idle got busy=%0b st=%0d want busy=0 st=0", bus.busy, bus.env_state);
    end
  endtask

  task automatic test_simultaneous();
    int m;
    pulse_on();
    tick();
    tick();
    pulse_off();
    tick();
    tick();
`ifdef ENVELOPE_EXP_RELEASE_EN
    m = exp_rel(exp_rel(128));
`else
    m = 64;
`endif
    total++;
    if (bus.env_level !== 8'(m) || bus.env_state !== 3'd4) begin
      bad++; $display("FAIL sim_setup got lv=%0d st=%0d want lv=%0d st=4", bus.env_level, bus.env_state, m);
    end
    @(negedge clk) begin bus.note_on = 1; bus.note_off = 1; bus.sample_en = 1; end
    @(negedge clk) begin bus.note_on = 0; bus.note_off = 0; bus.sample_en = 0; end
    total++;
    if (bus.env_level !== 8'(m) || bus.env_state !== 3'd1) begin
      bad++; $display("FAIL sim_event got lv=%0d st=%0d want lv=%0d st=1", bus.env_level, bus.env_state, m);
    end
    tick();
    total++;
    if (bus.env_level !== 8'(m + 64) || bus.env_state !== 3'd1) begin
      bad++; $display("FAIL sim_next got lv=%0d st=%0d want lv=%0d st=1", bus.env_level, bus.env_state, m + 64);
    end
  endtask

  task automatic test_async_reset();
    pulse_off();
    for (int i = 0; i < 12 && bus.env_state != 3'd0; i++) tick();
    bus.sample_in = 8'd200;
    pulse_on();
    tick();
    tick();
    total++;
    if (bus.env_level !== 8'd128 || bus.env_state !== 3'd1 || bus.sample_out !== 8'd50) begin
      bad++; $display("FAIL ar_setup got lv=%0d st=%0d out=%0d want lv=128 st=1 out=50", bus.env_level, bus.env_state, bus.sample_out);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.env_state, bus.env_level, bus.sample_out, bus.busy} !== 20'd0) begin
      bad++; $display("FAIL async_reset got st=%0d lv=%0d out=%0d busy=%0b want all 0", bus.env_state, bus.env_level, bus.sample_out, bus.busy);
    end
    @(negedge clk) reset = 1'b1;
    pulse_on();
    tick();
    total++;
    if (bus.env_level !== 8'd64 || bus.env_state !== 3'd1) begin
      bad++; $display("FAIL ar_restart got lv=%0d st=%0d want lv=64 st=1", bus.env_level, bus.env_state);
    end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_scaling();
    test_release();
    test_simultaneous();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/envelope_shaper.md
Name: envelope_shaper

Overview:
- Amplitude envelope (ADSR) stage between the sine generator and the PWM DAC.
- Takes unsigned N-bit sine magnitude samples and scales each by an E-bit envelope level stepped once per fs tick.
- The melody sequencer drives note_on/note_off at tone boundaries, so tone changes no longer click.
- Two instances per voice, one for the positive half-wave and one for the negative half-wave, sharing the note controls.

Parameters:
- N, 8, sample width (same as the DAC input width).
- E, 8, envelope level width; ENV_MAX = 2^E-1.
- ATTACK_STEP, 64, level increment per fs tick in ATTACK.
- DECAY_STEP, 16, level decrement per fs tick in DECAY.
- SUSTAIN_LEVEL, 128, level held in SUSTAIN; must be ≤ ENV_MAX.
- RELEASE_STEP, 32, level decrement per fs tick in RELEASE.

Ports:
- clk  in  1  system clock (1 MHz).
- reset  in  1  asynchronous, active-low reset.
- sample_en  in  1  one-cycle fs strobe (8 kHz), the clkgen fs output edge-detected.
- note_on  in  1  one-cycle pulse: start or retrigger the tone.
- note_off  in  1  one-cycle pulse: release the tone.
- sample_in  in  N  unsigned sine magnitude.
- sample_out  out  N  scaled sample, registered.
- env_level  out  E  current envelope level.
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- busy  out  1  high whenever env_state != IDLE.

Behaviour:
- Reset (reset=0, asynchronous): env_state=IDLE, env_level=0, sample_out=0, busy=0.
- Event handling in any cycle:
  - note_on → state ATTACK; env_level unchanged, so a retrigger from DECAY/SUSTAIN/RELEASE ramps up from the current level.
  - note_off → RELEASE if state is ATTACK, DECAY or SUSTAIN; ignored in IDLE and RELEASE.
  - note_on and note_off in the same cycle: note_on wins.
- An event cycle applies no level step, even if sample_en is high in that cycle.
- Level step, on a sample_en cycle with no event. All arithmetic uses saturating (E+1)-bit intermediates with no wrap.
  - ATTACK: level + ATTACK_STEP. If the sum is ≥ ENV_MAX, level=ENV_MAX and state → DECAY.
  - DECAY: level − DECAY_STEP. If the result is ≤ SUSTAIN_LEVEL or underflows, level=SUSTAIN_LEVEL and state → SUSTAIN.
  - SUSTAIN: hold the level.
  - RELEASE: level − RELEASE_STEP. If the result is ≤ 0, level=0 and state → IDLE.
  - IDLE: hold 0.
- Scaling:
  - Computed on sample_en cycles only; sample_out otherwise holds its value.
  - sample_out = sample_in when the current (pre-step) env_level == ENV_MAX.
  - Otherwise sample_out = (sample_in × env_level) >> E, using the full N+E-bit product and taking the upper N bits.
  - Latency: sample_out is valid 1 clk after the sample_en cycle and uses the env_level value from before that cycle's step.
- Reset asserted mid-tone: immediate return to the reset values; no release ramp.
- sample_en held high for consecutive cycles: each cycle counts as a tick; no edge detection is done inside the block.

Optional Feature:
- Macro: ENVELOPE_EXP_RELEASE_EN.
- Defined: the RELEASE step becomes level − (level >> 3) − 1, saturating at 0; RELEASE_STEP is unused. This gives an exponential-like tail that reaches 0 within 40 ticks from ENV_MAX.
- Undefined: linear RELEASE as specified above.
- All other states are identical in both builds.

Test Plan:
- Reset, then 4 sample_en ticks with no note event → env_state=0, env_level=0, sample_out=0, busy=0 throughout.
- note_on, then sample_en ticks with defaults:
  - env_level follows 64, 128, 192, 255 and the state becomes DECAY after tick 4.
  - It then follows 239, 223, …, 143, and reaches 128 with state SUSTAIN after 8 more ticks.
- In SUSTAIN (level 128) with sample_in=200 → sample_out=100 one clk after sample_en; with sample_in=255 → sample_out=127.
- From SUSTAIN, note_off then ticks → 96, 64, 32, 0, state IDLE and busy=0 after the 4th tick; with the macro defined, the level decays geometrically to 0 and the state becomes IDLE.
- In RELEASE at level 64, note_on and note_off in the same cycle with sample_en high → state ATTACK, level stays 64 that cycle, next tick gives 128.
- Assert reset mid-ATTACK at level 128, asynchronously and between clock edges → outputs are 0 and state IDLE immediately; after release, a note_on starts again from 0.
